prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Sequences the 9-bit-ISA core through its benchmark programs under the test-bench req/ack handshake.
- On each accepted req it selects the next program, holds the core in init with that program's start PC, and releases the core to run.
- It watches the core PC for the halt address, then raises ack.
- It also reports the cycle count, a timeout flag and the index of the program run.

Parameters:
- A, 16, PC / instruction-address width.
- NPROG, 3, number of programs; program index wraps modulo NPROG.
- CW, 16, cycle-counter width.
- HALT_PC, 16'h01FF, core PC value that signals program completion.
- INIT_CYC, 2, cycles core_init is held high per start (1..15).
- TIMEOUT, 16'hFFF0, max RUN cycles before forced completion (must be < 2^CW).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous active-high reset; forces IDLE and clears all registers.
- req  in  1  bench request "do next program"; sampled only in IDLE.
- base_pc  in  NPROG*A  start PCs, program k at bits [k*A +: A].
- core_pc  in  A  current core PC.
- ack  out  1  completion flag to bench; registered.
- core_init  out  1  core init/PC-load strobe.
- core_start_pc  out  A  PC loaded into the core while core_init=1.
- core_run  out  1  core enable; high only in RUN.
- prog_idx  out  $clog2(NPROG) (min 1)  index of program running or last run.
- cycle_count  out  CW  RUN cycles of last completed program (live count while running).
- timeout  out  1  last program ended by TIMEOUT.
- busy  out  1  high in LOAD or RUN.

Behaviour:
- States are IDLE, LOAD and RUN; the state is registered.
- Reset (async, any state, mid-run included) sets:
  - state=IDLE; ack=0, core_init=0, core_run=0, busy=0, timeout=0;
  - cycle_count=0, prog_idx=0, next_idx=0, core_start_pc=0.
- IDLE:
  - Outputs core_init=0, core_run=0; ack holds its value.
  - On req=1 at posedge, the req is accepted:
    - prog_idx<=next_idx; next_idx<=(next_idx==NPROG-1)?0:next_idx+1;
    - ack<=0, timeout<=0, cycle_count<=0;
    - init counter<=0; state<=LOAD.
- LOAD:
  - core_init=1, core_start_pc=base_pc[prog_idx], busy=1, core_run=0.
  - The init counter increments each cycle; after exactly INIT_CYC LOAD cycles, state<=RUN.
- RUN:
  - core_run=1, busy=1, core_init=0; cycle_count increments by 1 each RUN cycle.
  - If core_pc==HALT_PC: state<=IDLE, ack<=1, timeout<=0.
    - cycle_count includes the detect cycle, so a halt seen on the first RUN cycle gives cycle_count=1.
  - Else if cycle_count+1==TIMEOUT: state<=IDLE, ack<=1, timeout<=1, cycle_count=TIMEOUT.
  - Halt and timeout in the same cycle: halt wins, timeout=0.
- req while in LOAD or RUN is ignored; it is not queued.
- req held high across completion starts the next program on the first IDLE cycle.
  - In that case ack is high for exactly one cycle.
- Latency from accepted req to first core_run=1 is INIT_CYC+1 posedges.
- ack is a level: it stays 1 in IDLE until the next accepted req or reset.
- cycle_count never wraps: TIMEOUT < 2^CW guarantees this.
- prog_idx is stable from acceptance through the following IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from req or core_pc to any output.

Test Plan:
- Reset then IDLE:
  - Stimulus: assert reset mid-cycle (async), release, req=0 for 5 cycles.
  - Required: ack=0, busy=0, core_init=0, core_run=0, prog_idx=0.
- Normal run:
  - Stimulus: base_pc={16'h0080,16'h0040,16'h0000}, one-cycle req, core_pc=HALT_PC on the 10th RUN cycle.
  - Required: core_init=1 for 2 cycles with core_start_pc=0; core_run=1 for 10 cycles; then ack=1, cycle_count=10, timeout=0, prog_idx=0.
- Wrap sequence:
  - Stimulus: four consecutive req/halt rounds.
  - Required: prog_idx 0,1,2,0; core_start_pc 16'h0000, 16'h0040, 16'h0080, 16'h0000.
- Timeout:
  - Stimulus: TIMEOUT overridden to 20, core_pc never equals HALT_PC.
  - Required: ack=1 after 20 RUN cycles, timeout=1, cycle_count=20.
- Simultaneous halt and timeout:
  - Stimulus: TIMEOUT=20, halt on RUN cycle 20.
  - Required: ack=1, timeout=0, cycle_count=20.
- req ignored and reset mid-run:
  - Stimulus: req pulses during LOAD/RUN.
  - Required: no restart; prog_idx unchanged.
  - Stimulus: then assert reset in RUN cycle 5.
  - Required: immediately IDLE, core_run=0, ack=0; the next req runs program 0.

Source files
------------

// File: rtl/prog_sequencer.sv
// prog_sequencer
//   Steps the 9-bit-ISA core through its benchmark programs under the bench
//   req/ack handshake.
//
//   Operation:
//     - Each accepted req selects the next program (round robin over NPROG).
//     - The core is held in init for INIT_CYC cycles with that program's
//       start PC.
//     - The core is then released to run until its PC reaches HALT_PC, or
//       until TIMEOUT run cycles have elapsed.
//     - At completion ack is raised and held until the next accepted req.
//
//   Ports:
//     clk           in   clock, all state updates on posedge
//     reset         in   asynchronous active-high reset
//     req           in   "do next program", sampled only in IDLE
//     base_pc       in   start PCs, program k at [k*A +: A]
//     core_pc       in   current core PC
//     ack           out  completion level, held until the next accepted req
//     core_init     out  core init / PC-load strobe (LOAD state)
//     core_start_pc out  PC loaded into the core while core_init=1
//     core_run      out  core enable (RUN state)
//     prog_idx      out  index of the program running or last run
//     cycle_count   out  RUN cycles of the last program (live while running)
//     timeout       out  last program was ended by TIMEOUT
//     busy          out  high in LOAD or RUN
module prog_sequencer #(
  parameter int unsigned     A        = 16,
  parameter int unsigned     NPROG    = 3,
  parameter int unsigned     CW       = 16,
  parameter logic [A-1:0]    HALT_PC  = 16'h01FF,
  parameter int unsigned     INIT_CYC = 2,
  parameter logic [CW-1:0]   TIMEOUT  = 16'hFFF0,
  localparam int unsigned    PW       = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic [NPROG*A-1:0] base_pc,
  input  logic [A-1:0]       core_pc,
  output logic               ack,
  output logic               core_init,
  output logic [A-1:0]       core_start_pc,
  output logic               core_run,
  output logic [PW-1:0]      prog_idx,
  output logic [CW-1:0]      cycle_count,
  output logic               timeout,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t          state_q,       state_d;
  logic            ack_q,         ack_d;
  logic            timeout_q,     timeout_d;
  logic [CW-1:0]   cycle_count_q, cycle_count_d;
  logic [PW-1:0]   prog_idx_q,    prog_idx_d;
  logic [PW-1:0]   next_idx_q,    next_idx_d;
  logic [A-1:0]    start_pc_q,    start_pc_d;
  logic [3:0]      init_cnt_q,    init_cnt_d;
  logic [CW-1:0]   cycle_inc;

  assign cycle_inc = cycle_count_q + CW'(1);

  // NOTE: always_comb assigns every *_d a default (hold) first, so no path
  // through the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ack_d         = ack_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    prog_idx_d    = prog_idx_q;
    next_idx_d    = next_idx_q;
    start_pc_d    = start_pc_q;
    init_cnt_d    = init_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          prog_idx_d    = next_idx_q;
          next_idx_d    = (next_idx_q == PW'(NPROG - 1)) ? '0 : next_idx_q + 1'b1;
          // Capture the start PC now so core_start_pc is a flop output
          // that is already valid on the first LOAD cycle.
          start_pc_d    = base_pc[next_idx_q*A +: A];
          ack_d         = 1'b0;
          timeout_d     = 1'b0;
          cycle_count_d = '0;
          init_cnt_d    = '0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        if (init_cnt_q == 4'(INIT_CYC - 1)) state_d = RUN;
        else                                init_cnt_d = init_cnt_q + 4'd1;
      end
      RUN: begin
        // The detect cycle counts, so a halt on the first RUN cycle reports 1.
        cycle_count_d = cycle_inc;
        if (core_pc == HALT_PC) begin
          state_d   = IDLE;
          ack_d     = 1'b1;
          timeout_d = 1'b0;
        end else if (cycle_inc == TIMEOUT) begin
          state_d   = IDLE;
          ack_d     = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ack_q         <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      prog_idx_q    <= '0;
      next_idx_q    <= '0;
      start_pc_q    <= '0;
      init_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ack_q         <= ack_d;
      timeout_q     <= timeout_d;
      cycle_count_q <= cycle_count_d;
      prog_idx_q    <= prog_idx_d;
      next_idx_q    <= next_idx_d;
      start_pc_q    <= start_pc_d;
      init_cnt_q    <= init_cnt_d;
    end
  end

  // Strobes are decoded from the state register only.
  assign core_init     = (state_q == LOAD);
  assign core_run      = (state_q == RUN);
  assign busy          = (state_q != IDLE);
  assign ack           = ack_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_count_q;
  assign prog_idx      = prog_idx_q;
  assign core_start_pc = start_pc_q;

endmodule

// File: tb/tb_prog_sequencer.sv
module tb_prog_sequencer;

  localparam int          A        = 16;
  localparam int          NPROG    = 3;
  localparam int          CW       = 16;
  localparam logic [15:0] HALT     = 16'h01FF;
  localparam int          INIT_CYC = 2;
  localparam int          TMO      = 20;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               req = 1'b0;
  logic [NPROG*A-1:0] base_pc = {16'h0080, 16'h0040, 16'h0000};
  logic [A-1:0]       core_pc = 16'h0000;
  logic               ack, core_init, core_run, timeout, busy;
  logic [A-1:0]       core_start_pc;
  logic [1:0]         prog_idx;
  logic [CW-1:0]      cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  prog_sequencer #(
    .A(A), .NPROG(NPROG), .CW(CW), .HALT_PC(HALT),
    .INIT_CYC(INIT_CYC), .TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk), .reset(reset), .req(req), .base_pc(base_pc), .core_pc(core_pc),
    .ack(ack), .core_init(core_init), .core_start_pc(core_start_pc),
    .core_run(core_run), .prog_idx(prog_idx), .cycle_count(cycle_count),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: a program is "running" from acceptance until
  // completion; m_t counts cycles since acceptance, so the first INIT_CYC of
  // them are init cycles and the rest are run cycles.
  bit          m_run;
  int          m_t, m_idx, m_next, m_cnt;
  bit          m_ack, m_tout;
  logic [15:0] m_spc;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_run <= 0; m_t <= 0; m_idx <= 0; m_next <= 0; m_cnt <= 0;
      m_ack <= 0; m_tout <= 0; m_spc <= '0;
    end else if (!m_run) begin
      if (req) begin
        m_run  <= 1;
        m_t    <= 0;
        m_idx  <= m_next;
        m_next <= (m_next + 1) % NPROG;
        m_spc  <= base_pc[m_next*A +: A];
        m_ack  <= 0;
        m_tout <= 0;
        m_cnt  <= 0;
      end
    end else begin
      m_t <= m_t + 1;
      if (m_t >= INIT_CYC) begin
        m_cnt <= m_cnt + 1;
        if (core_pc == HALT) begin
          m_run <= 0; m_ack <= 1; m_tout <= 0;
        end else if (m_cnt + 1 == TMO) begin
          m_run <= 0; m_ack <= 1; m_tout <= 1;
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ack",           32'(ack),           32'(m_ack));
      check("core_init",     32'(core_init),     32'(m_run && m_t < INIT_CYC));
      check("core_run",      32'(core_run),      32'(m_run && m_t >= INIT_CYC));
      check("busy",          32'(busy),          32'(m_run));
      check("prog_idx",      32'(prog_idx),      32'(m_idx));
      check("cycle_count",   32'(cycle_count),   32'(m_cnt));
      check("timeout",       32'(timeout),       32'(m_tout));
      check("core_start_pc", 32'(core_start_pc), 32'(m_spc));
    end
  end

  // One req/complete round. halt_at: RUN cycle on which core_pc=HALT (0 =
  // never). noise: random req pulses while busy. reset_at: RUN cycle on
  // which reset is asserted asynchronously (0 = never).
  task automatic do_round(input int halt_at, input bit noise, input int reset_at,
                          output int n_init, output int n_run, output logic [15:0] spc);
    bit done = 0;
    n_init = 0; n_run = 0; spc = 'x;
    @(negedge clk); req = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      req = 1'b0;
      if (core_init) begin n_init++; spc = core_start_pc; end
      if (core_run) n_run++;
      core_pc = (core_run && n_run == halt_at) ? HALT : 16'($urandom_range(0, 16'h01FE));
      if (noise && busy) req = 1'($urandom_range(0, 1));
      if (reset_at != 0 && core_run && n_run == reset_at) begin
        #2 reset = 1'b1;
        #1;
        check("rst_core_run", 32'(core_run), 0);
        check("rst_ack",      32'(ack),      0);
        check("rst_busy",     32'(busy),     0);
        check("rst_prog_idx", 32'(prog_idx), 0);
        @(negedge clk); reset = 1'b0; req = 1'b0;
        done = 1;
      end else if (ack) begin
        req = 1'b0;
        done = 1;
      end
    end
    if (!done) check("round_completed", 0, 1);
  endtask

  int          ni, nr, ack_run, ack_max;
  logic [15:0] spc;
  int          exp_idx [4] = '{0, 1, 2, 0};
  logic [15:0] exp_spc [4] = '{16'h0000, 16'h0040, 16'h0080, 16'h0000};

  initial begin
    // Reset and idle
    #12 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #2 reset = 1'b1;   // asynchronous, mid-cycle
    #1 check("async_reset_busy", 32'(busy), 0);
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_ack",       32'(ack),       0);
    check("idle_busy",      32'(busy),      0);
    check("idle_core_init", 32'(core_init), 0);
    check("idle_core_run",  32'(core_run),  0);
    check("idle_prog_idx",  32'(prog_idx),  0);

    // Normal run, then the wrap sequence
    for (int r = 0; r < 4; r++) begin
      do_round(10, 0, 0, ni, nr, spc);
      check("wrap_prog_idx", 32'(prog_idx), 32'(exp_idx[r]));
      check("wrap_start_pc", 32'(spc),      32'(exp_spc[r]));
      if (r == 0) begin
        check("normal_init_cycles", 32'(ni),          2);
        check("normal_run_cycles",  32'(nr),          10);
        check("normal_ack",         32'(ack),         1);
        check("normal_cycle_count", 32'(cycle_count), 10);
        check("normal_timeout",     32'(timeout),     0);
      end
    end

    // Timeout: no halt ever seen (program 1)
    do_round(0, 0, 0, ni, nr, spc);
    check("tmo_run_cycles",  32'(nr),          20);
    check("tmo_ack",         32'(ack),         1);
    check("tmo_timeout",     32'(timeout),     1);
    check("tmo_cycle_count", 32'(cycle_count), 20);

    // Halt on the same cycle as timeout: halt wins (program 2)
    do_round(20, 0, 0, ni, nr, spc);
    check("sim_ack",         32'(ack),         1);
    check("sim_timeout",     32'(timeout),     0);
    check("sim_cycle_count", 32'(cycle_count), 20);

    // req pulses while busy are ignored (program 0)
    do_round(7, 1, 0, ni, nr, spc);
    check("noise_init_cycles", 32'(ni),          2);
    check("noise_run_cycles",  32'(nr),          7);
    check("noise_prog_idx",    32'(prog_idx),    0);
    check("noise_cycle_count", 32'(cycle_count), 7);

    // Reset in RUN cycle 5 of program 1, then the next req runs program 0
    do_round(0, 0, 5, ni, nr, spc);
    do_round(3, 0, 0, ni, nr, spc);
    check("post_rst_prog_idx", 32'(prog_idx), 0);
    check("post_rst_start_pc", 32'(spc),      0);

    // req held across completions: ack lasts exactly one cycle each time
    ack_run = 0; ack_max = 0;
    @(negedge clk); req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      core_pc = core_run ? HALT : 16'h0010;
      ack_run = ack ? ack_run + 1 : 0;
      if (ack_run > ack_max) ack_max = ack_run;
    end
    req = 1'b0;
    check("held_req_ack_len", 32'(ack_max), 1);
    for (int i = 0; i < 50 && !(ack && !busy); i++) begin
      @(negedge clk);
      core_pc = core_run ? HALT : 16'h0010;
    end
    check("held_req_done",        32'(ack && !busy), 1);
    check("held_req_cycle_count", 32'(cycle_count),  1);

    // Randomized rounds with random start PCs, halts and req noise
    @(negedge clk);
    base_pc = {16'($urandom), 16'($urandom), 16'($urandom)};
    for (int r = 0; r < 25; r++)
      do_round(int'($urandom_range(1, 24)), 1'($urandom_range(0, 1)), 0, ni, nr, spc);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
